bin_to_bcd_converter: RTL and testbench

- Sequential double-dabble converter from binary to packed BCD.
- Sits directly upstream of the 4-digit seven-segment display stage. It turns a register value into a 16-bit word whose four nibbles are each 0-9, so the display shows decimal rather than hex.
- Start/done handshake. The result is held stable between conversions so the display multiplexer can sample it at any time.

---
 rtl/bin_to_bcd_converter_if.sv | 30 +++
 rtl/bin_to_bcd_converter.sv | 112 +++++++++++
 tb/tb_bin_to_bcd_converter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/bin_to_bcd_converter_if.sv
// rtl/bin_to_bcd_converter_if.sv - start/done handshake and result bus of the binary-to-BCD converter
interface bin_to_bcd_converter_if #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin_in;
    logic                  busy;
    logic                  done;
    logic                  overflow;
    logic [4*DIGITS-1:0]   bcd_out;

    modport master (
        output start,
        output bin_in,
        input  busy,
        input  done,
        input  overflow,
        input  bcd_out
    );

    modport slave (
        input  start,
        input  bin_in,
        output busy,
        output done,
        output overflow,
        output bcd_out
    );
endinterface

// File: rtl/bin_to_bcd_converter.sv
// rtl/bin_to_bcd_converter.sv - sequential double-dabble binary to packed BCD converter (optional AUTO_CONV_EN)
module bin_to_bcd_converter #(
    parameter int IN_WIDTH = 14,
    parameter int DIGITS   = 4
) (
    input  logic                   clock,
    input  logic                   reset_n,
    bin_to_bcd_converter_if.slave  bus
);
    localparam int ACC_W = 4 * (DIGITS + 1);
    localparam int OUT_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam logic [31:0] MAX_VAL = 32'(10 ** DIGITS - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t              state;
    logic [IN_WIDTH-1:0] shreg;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_adj;
    logic [CNT_W-1:0]    cnt;
    logic                over_range;
    logic [OUT_W-1:0]    bcd_r;
    logic                overflow_r;
    logic                busy_r;
    logic                done_r;
    logic                trigger;

    assign bus.bcd_out  = bcd_r;
    assign bus.overflow = overflow_r;
    assign bus.busy     = busy_r;
    assign bus.done     = done_r;

`ifdef AUTO_CONV_EN
    logic [IN_WIDTH-1:0] last_bin;

    assign trigger = bus.start | (bus.bin_in != last_bin);

    // Remember the value of the last capture so a changed input retriggers a conversion
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            last_bin <= '0;
        end else if (state == IDLE && trigger) begin
            last_bin <= bus.bin_in;
        end
    end
`else
    assign trigger = bus.start;
`endif

    // Add-3 correction on every accumulator digit that is 5 or more, all in parallel
    always_comb begin
        acc_adj = acc;
        for (int d = 0; d < DIGITS + 1; d++) begin
            if (acc[d*4 +: 4] >= 4'd5) begin
                acc_adj[d*4 +: 4] = acc[d*4 +: 4] + 4'd3;
            end
        end
    end

    // Conversion FSM; result registers change only on the edge that enters DONE
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state      <= IDLE;
            shreg      <= '0;
            acc        <= '0;
            cnt        <= '0;
            over_range <= 1'b0;
            bcd_r      <= '0;
            overflow_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (trigger) begin
                        shreg      <= bus.bin_in;
                        acc        <= '0;
                        over_range <= (32'(bus.bin_in) > MAX_VAL);
                        cnt        <= CNT_W'(IN_WIDTH);
                        busy_r     <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (cnt != '0) begin
                        acc   <= {acc_adj[ACC_W-2:0], shreg[IN_WIDTH-1]};
                        shreg <= {shreg[IN_WIDTH-2:0], 1'b0};
                        cnt   <= cnt - 1'b1;
                    end else begin
                        // Clamp to all nines so the display never sees a truncated value
                        bcd_r      <= over_range ? {DIGITS{4'h9}} : acc[OUT_W-1:0];
                        overflow_r <= over_range;
                        busy_r     <= 1'b0;
                        done_r     <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done_r <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_converter.sv
// tb/tb_bin_to_bcd_converter.sv - scoreboard testbench for bin_to_bcd_converter
module tb_bin_to_bcd_converter;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;
    logic [16:0] exp_q[$];
    logic [15:0] last_bcd = 16'h0000;

    always #5 clock = ~clock;

    bin_to_bcd_converter_if #(.IN_WIDTH(14), .DIGITS(4)) bus ();

    bin_to_bcd_converter #(.IN_WIDTH(14), .DIGITS(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] model(input int value);
        logic [15:0] r;
        int v;
        if (value > 9999) return {1'b1, 16'h9999};
        r = '0;
        v = value;
        for (int i = 0; i < 4; i++) begin
            r[i*4 +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return {1'b0, r};
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Wait for done, compare against the scoreboard head, then confirm no repeat pulse
    task automatic wait_result(input string tag, input int value, input int glitch_at, input int glitch_val);
        logic [16:0] exp;
        int dones = 0;
        int lat = -1;
        for (int n = 1; n <= 40; n++) begin
            tick();
            if (n == glitch_at) begin
                bus.bin_in = 14'(glitch_val);
                bus.start  = 1'b1;
            end else if (n == glitch_at + 1) begin
                bus.bin_in = 14'(value);
                bus.start  = 1'b0;
            end
            if (n == 5) check_eq({tag, "_hold"}, 32'(bus.bcd_out), 32'(last_bcd));
            if (n == 14) check_eq({tag, "_busy"}, 32'(bus.busy), 32'd1);
            if (bus.done) begin
                dones++;
                if (lat < 0) begin
                    lat = n;
                    check_eq({tag, "_latency"}, 32'(n), 32'd15);
                    check_eq({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
                    if (exp_q.size() == 0) begin
                        check_eq({tag, "_queue_empty"}, 32'd1, 32'd0);
                    end else begin
                        exp = exp_q.pop_front();
                        check_eq({tag, "_bcd"}, 32'(bus.bcd_out), 32'(exp[15:0]));
                        check_eq({tag, "_ovf"}, 32'(bus.overflow), 32'(exp[16]));
                        last_bcd = exp[15:0];
                    end
                end
            end
        end
        check_eq({tag, "_done_count"}, 32'(dones), 32'd1);
    endtask

    task automatic run_conv(input string tag, input int value, input int glitch_at, input int glitch_val);
        bus.bin_in = 14'(value);
        bus.start  = 1'b1;
        exp_q.push_back(model(value));
        tick();
        bus.start = 1'b0;
        wait_result(tag, value, glitch_at, glitch_val);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.bin_in = '0;
        reset_n    = 1'b0;
        tick();
        tick();
        check_eq("rst_bcd", 32'(bus.bcd_out), 32'h0);
        check_eq("rst_ovf", 32'(bus.overflow), 32'h0);
        check_eq("rst_busy", 32'(bus.busy), 32'h0);
        check_eq("rst_done", 32'(bus.done), 32'h0);
        reset_n = 1'b1;
        tick();

        run_conv("c1234", 1234, 0, 0);
        run_conv("c0", 0, 0, 0);
        run_conv("c9999", 9999, 0, 0);
        run_conv("c10000", 10000, 0, 0);
        run_conv("c16383", 16383, 0, 0);
        run_conv("c4321", 4321, 5, 55);
        run_conv("c0507", 507, 3, 16000);

        // Reset in the middle of a conversion aborts it
        begin
            int dones = 0;
            bus.bin_in = 14'd8765;
            bus.start  = 1'b1;
            tick();
            bus.start = 1'b0;
            for (int n = 1; n <= 7; n++) begin
                tick();
                if (bus.done) dones++;
            end
            reset_n    = 1'b0;
            bus.bin_in = '0;
            tick();
            reset_n = 1'b1;
            check_eq("abort_bcd", 32'(bus.bcd_out), 32'h0);
            check_eq("abort_busy", 32'(bus.busy), 32'h0);
            check_eq("abort_ovf", 32'(bus.overflow), 32'h0);
            for (int n = 0; n < 20; n++) begin
                tick();
                if (bus.done) dones++;
            end
            check_eq("abort_no_done", 32'(dones), 32'd0);
            last_bcd = 16'h0000;
        end
        run_conv("c42", 42, 0, 0);

`ifdef AUTO_CONV_EN
        run_conv("a0", 0, 0, 0);
        bus.bin_in = 14'd305;
        exp_q.push_back(model(305));
        tick();
        wait_result("auto305", 305, 0, 0);
`endif

        check_eq("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
